// File: rtl/fmt_pkt_sink.sv
// Packet sink: grants formatter requests when the FWFT buffer has room, stores
// words tagged with channel ID and last flag, and flags length/protocol errors.
module fmt_pkt_sink #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fmt_req,
    input  logic [1:0]  fmt_chid,
    input  logic [4:0]  fmt_length,
    output logic        fmt_grant,
    input  logic        fmt_start,
    input  logic [31:0] fmt_data,
    input  logic        fmt_end,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic [1:0]  rd_chid,
    output logic        rd_last,
    output logic        err_len,
    output logic        err_proto,
    input  logic        err_clr,
    output logic [15:0] pkt_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_START, RECV} state_t;

    state_t         state_q, state_d;
    logic [1:0]     chid_q, chid_d;
    logic [5:0]     len_q, len_d;
    logic [5:0]     wcnt_q, wcnt_d;
    logic [1:0]     tmo_q, tmo_d;
    logic           zreq_q, zreq_d;
    logic           ign_q, ign_d;
    logic           grant_q, grant_d;
    logic           err_len_q, err_len_d;
    logic           err_proto_q, err_proto_d;
    logic [15:0]    pkt_q, pkt_d;
    logic [AW:0]    occ_q, occ_d;
    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [34:0]    mem [DEPTH];

    logic           wr_en, wr_last, rd_fire, set_len, set_proto, done;
    logic [5:0]     cnt_new;
    logic [AW:0]    free_w;

    assign free_w  = DEPTH_W - occ_q;
    assign rd_fire = (occ_q != '0) && rd_ready;

    always_comb begin
        state_d   = state_q;
        chid_d    = chid_q;
        len_d     = len_q;
        wcnt_d    = wcnt_q;
        tmo_d     = tmo_q;
        zreq_d    = zreq_q && fmt_req;
        ign_d     = ign_q;
        wr_en     = 1'b0;
        wr_last   = 1'b0;
        set_len   = 1'b0;
        set_proto = 1'b0;
        done      = 1'b0;
        cnt_new   = (state_q == RECV) ? wcnt_q + 6'd1 : 6'd1;

        // Idle/grant: stray start/end is an error unless we are draining the
        // tail of a packet abandoned by reset or by a length overrun.
        if (state_q == IDLE || state_q == GRANT) begin
            if (ign_q) begin
                if (fmt_end) ign_d = 1'b0;
            end else if (fmt_start || fmt_end) begin
                set_proto = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (fmt_req && fmt_length == 5'd0) begin
                    set_proto = set_proto || !zreq_q;
                    zreq_d    = 1'b1;
                end else if (fmt_req && free_w >= (AW+1)'(fmt_length)) begin
                    state_d = GRANT;
                    chid_d  = fmt_chid;
                    len_d   = {1'b0, fmt_length};
                    wcnt_d  = 6'd0;
                end
            end
            GRANT: begin
                state_d = WAIT_START;
                tmo_d   = 2'd0;
                ign_d   = 1'b0;
            end
            WAIT_START: begin
                if (fmt_start) begin
                    wr_en   = 1'b1;
                    wcnt_d  = 6'd1;
                    state_d = RECV;
                end else if (tmo_q == 2'd3) begin
                    set_proto = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 2'd1;
                end
            end
            RECV: begin
                wr_en  = 1'b1;
                wcnt_d = cnt_new;
            end
            default: state_d = IDLE;
        endcase

        // A packet closes on fmt_end or on reaching its length, whichever first.
        if (wr_en) begin
            done    = fmt_end || (cnt_new == len_q);
            wr_last = done;
            if (done) begin
                state_d = IDLE;
                wcnt_d  = 6'd0;
                set_len = !fmt_end || (cnt_new != len_q);
                if (!fmt_end) ign_d = 1'b1;
            end
        end

        grant_d     = (state_d == GRANT);
        err_len_d   = (err_len_q && !err_clr) || set_len;
        err_proto_d = (err_proto_q && !err_clr) || set_proto;
        pkt_d       = pkt_q + 16'(done);
        occ_d       = occ_q + (AW+1)'(wr_en) - (AW+1)'(rd_fire);
        wptr_d      = wptr_q + AW'(wr_en);
        rptr_d      = rptr_q + AW'(rd_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            chid_q      <= 2'd0;
            len_q       <= 6'd0;
            wcnt_q      <= 6'd0;
            tmo_q       <= 2'd0;
            zreq_q      <= 1'b0;
            ign_q       <= 1'b1;
            grant_q     <= 1'b0;
            err_len_q   <= 1'b0;
            err_proto_q <= 1'b0;
            pkt_q       <= 16'd0;
            occ_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            state_q     <= state_d;
            chid_q      <= chid_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            tmo_q       <= tmo_d;
            zreq_q      <= zreq_d;
            ign_q       <= ign_d;
            grant_q     <= grant_d;
            err_len_q   <= err_len_d;
            err_proto_q <= err_proto_d;
            pkt_q       <= pkt_d;
            occ_q       <= occ_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wptr_q] <= {wr_last, chid_q, fmt_data};
    end

    assign fmt_grant = grant_q;
    assign rd_valid  = (occ_q != '0);
    assign {rd_last, rd_chid, rd_data} = mem[rptr_q];
    assign err_len   = err_len_q;
    assign err_proto = err_proto_q;
    assign pkt_cnt   = pkt_q;
endmodule

// File: tb/tb_fmt_pkt_sink.sv
// Directed bench for fmt_pkt_sink: a queue model of stored words and packet
// count is checked every cycle; grant timing and error flags are checked inline.
module tb_fmt_pkt_sink;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fmt_req = 1'b0;
    logic [1:0]  fmt_chid = 2'd0;
    logic [4:0]  fmt_length = 5'd0;
    logic        fmt_grant;
    logic        fmt_start = 1'b0;
    logic [31:0] fmt_data = 32'd0;
    logic        fmt_end = 1'b0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic [1:0]  rd_chid;
    logic        rd_last;
    logic        err_len;
    logic        err_proto;
    logic        err_clr = 1'b0;
    logic [15:0] pkt_cnt;

    fmt_pkt_sink #(.DEPTH(64)) dut (
        .clk(clk), .rst(rst), .fmt_req(fmt_req), .fmt_chid(fmt_chid),
        .fmt_length(fmt_length), .fmt_grant(fmt_grant), .fmt_start(fmt_start),
        .fmt_data(fmt_data), .fmt_end(fmt_end), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_chid(rd_chid),
        .rd_last(rd_last), .err_len(err_len), .err_proto(err_proto),
        .err_clr(err_clr), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gnt_wait, gnt_cyc, rd_cyc;
    logic chk_en = 1'b0;

    // model: expected buffer contents {last, chid, data} and packet count
    logic [34:0] mq [$];
    logic [15:0] m_pkt = 16'd0;
    logic        exp_push = 1'b0;
    logic        exp_done = 1'b0;
    logic [34:0] exp_word = 35'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_pkt <= 16'd0;
        end else begin
            if (rd_ready && mq.size() > 0) void'(mq.pop_front());
            if (exp_push) mq.push_back(exp_word);
            if (exp_done) m_pkt <= m_pkt + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
            if (rd_valid && mq.size() > 0)
                chk("head_word", 64'({rd_last, rd_chid, rd_data}), 64'(mq[0]));
            chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Request, wait for grant, then send n words (end on word n); rst_at>0
    // asserts reset together with that word.
    task automatic send_pkt(input int chid, input int len, input int n, input int rst_at);
        int eff;
        logic got;
        logic stored;
        fmt_req    = 1'b1;
        fmt_chid   = chid[1:0];
        fmt_length = len[4:0];
        gnt_wait   = 0;
        got        = 1'b0;
        while (!got && gnt_wait < 100) begin
            tick(1);
            gnt_wait++;
            if (fmt_grant) got = 1'b1;
        end
        gnt_cyc = cyc;
        fmt_req = 1'b0;
        if (!got) begin
            chk("grant_timeout", 64'd0, 64'd1);
        end else begin
            tick(1);
            chk("grant_one_cycle", 64'(fmt_grant), 64'd0);
            eff = (n < len) ? n : len;
            for (int i = 1; i <= n; i++) begin
                fmt_start = (i == 1);
                fmt_end   = (i == n);
                fmt_data  = 32'hC0DE_0000 + 32'(chid * 4096) + 32'(len * 256) + 32'(i);
                rst       = (rst_at != 0 && i == rst_at);
                stored    = (rst_at == 0 || i < rst_at) && i <= eff;
                exp_push  = stored;
                exp_word  = {(i == eff), chid[1:0], fmt_data};
                exp_done  = stored && (i == eff);
                tick(1);
            end
            fmt_start = 1'b0;
            fmt_end   = 1'b0;
            rst       = 1'b0;
            exp_push  = 1'b0;
            exp_done  = 1'b0;
        end
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        rst = 1'b0;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_grant", 64'(fmt_grant), 64'd0);
        chk("rst_err_len", 64'(err_len), 64'd0);
        chk("rst_err_proto", 64'(err_proto), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk_en = 1'b1;

        // chid=2 len=4 into an empty buffer, consumer stalled
        send_pkt(2, 4, 4, 0);
        chk("s1_grant_latency", 64'(gnt_wait), 64'd1);
        chk("s1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("s1_head_chid", 64'(rd_chid), 64'd2);
        chk("s1_head_data", 64'(rd_data), 64'hC0DE_2401);
        rd_ready = 1'b1;
        tick(6);
        chk("s1_drained", 64'(rd_valid), 64'd0);

        // single-word packet: start and end together
        send_pkt(1, 1, 1, 0);
        tick(2);
        chk("s2_pkt_cnt", 64'(pkt_cnt), 64'd2);
        chk("s2_err_len", 64'(err_len), 64'd0);
        chk("s2_err_proto", 64'(err_proto), 64'd0);

        // stray fmt_start while idle
        fmt_start = 1'b1;
        tick(1);
        fmt_start = 1'b0;
        chk("stray_start_proto", 64'(err_proto), 64'd1);
        clear_errs();
        chk("clr_proto", 64'(err_proto), 64'd0);

        // len=3 with fmt_end on word 2
        rd_ready = 1'b0;
        send_pkt(3, 3, 2, 0);
        chk("s3_err_len", 64'(err_len), 64'd1);
        chk("s3_pkt_cnt", 64'(pkt_cnt), 64'd3);
        rd_ready = 1'b1;
        tick(4);
        clear_errs();
        chk("s3_clr_len", 64'(err_len), 64'd0);

        // grant with no fmt_start: error after the 4th waiting cycle
        fmt_req    = 1'b1;
        fmt_length = 5'd2;
        tick(1);
        chk("s4_grant", 64'(fmt_grant), 64'd1);
        fmt_req = 1'b0;
        tick(4);
        chk("s4_proto_before", 64'(err_proto), 64'd0);
        tick(1);
        chk("s4_proto_timeout", 64'(err_proto), 64'd1);
        send_pkt(1, 2, 2, 0);
        chk("s4_next_latency", 64'(gnt_wait), 64'd1);
        chk("s4_pkt_cnt", 64'(pkt_cnt), 64'd4);

        // zero-length request raced with err_clr: error wins, then only once
        fmt_req    = 1'b1;
        fmt_length = 5'd0;
        err_clr    = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("zl_err_beats_clr", 64'(err_proto), 64'd1);
        tick(2);
        chk("zl_no_grant", 64'(fmt_grant), 64'd0);
        clear_errs();
        tick(2);
        chk("zl_once_per_req", 64'(err_proto), 64'd0);
        chk("zl_still_no_grant", 64'(fmt_grant), 64'd0);
        fmt_req = 1'b0;
        tick(1);

        // occupancy 61, len=5 waits for two reads
        rd_ready = 1'b0;
        send_pkt(0, 31, 31, 0);
        send_pkt(3, 30, 30, 0);
        fork
            send_pkt(0, 5, 5, 0);
            begin
                tick(5);
                rd_ready = 1'b1;
                rd_cyc   = cyc;
                tick(2);
                rd_ready = 1'b0;
            end
        join
        chk("s5_grant_after_free", 64'(gnt_cyc), 64'(rd_cyc + 3));
        chk("s5_pkt_cnt", 64'(pkt_cnt), 64'd7);
        rd_ready = 1'b1;
        tick(70);
        chk("s5_drained", 64'(rd_valid), 64'd0);

        // len=2 overrun: words past length are dropped
        send_pkt(1, 2, 4, 0);
        tick(2);
        chk("ovr_err_len", 64'(err_len), 64'd1);
        chk("ovr_pkt_cnt", 64'(pkt_cnt), 64'd8);

        // reset on word 3 of a len=8 packet
        send_pkt(2, 8, 8, 3);
        chk("s6_rd_valid", 64'(rd_valid), 64'd0);
        chk("s6_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("s6_err_len", 64'(err_len), 64'd0);
        chk("s6_err_proto", 64'(err_proto), 64'd0);
        chk("s6_grant", 64'(fmt_grant), 64'd0);
        send_pkt(3, 2, 2, 0);
        chk("s6_next_latency", 64'(gnt_wait), 64'd1);
        tick(3);
        chk("s6_pkt_after", 64'(pkt_cnt), 64'd1);
        chk("s6_proto_after", 64'(err_proto), 64'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
